// File: rtl/or_share_arb_pkg.sv
// Shared definitions for the OR-share arbiter slice.
// Holds the default requester count and operand width, the helper that
// derives the requester-index width, and the result-slot state encoding.
package or_share_arb_pkg;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned WIDTH_DEF = 8;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned ID_W_DEF = id_width(N_REQ_DEF);

    // EMPTY: result register holds nothing; FULL: result register valid.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/or_share_arb_if.sv
// Handshake bundle for or_share_arb.
// Requester side : req_valid/req_ready per requester, operands req_a/req_b
//                  packed as [i*WIDTH +: WIDTH] per requester i.
// Result side    : res_valid/res_ready handshake, res_data (OR result),
//                  res_id (index of the requester that produced res_data).
// Modport slave is the arbiter's view; master is the environment's view.
interface or_share_arb_if
    import or_share_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
);
    localparam int unsigned ID_W = id_width(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   res_valid;
    logic                   res_ready;
    logic [WIDTH-1:0]       res_data;
    logic [ID_W-1:0]        res_id;

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id
    );

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id
    );

endinterface

// File: rtl/or_share_arb_rr_picker.sv
// Round-robin picker, purely combinational.
// req       : request vector (already qualified by the caller)
// ptr       : highest-priority index; search proceeds upward with wrap
// grant     : one-hot grant (all zero when nothing requested)
// grant_idx : binary index of the granted requester
// any_grant : high when some requester was granted
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_grant
);

    localparam logic [ID_W:0] N_L = (ID_W+1)'(N_REQ);

    // One extra bit so ptr+k can be reduced modulo N_REQ without overflow.
    logic [ID_W:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= N_L) begin
                cand = cand - N_L;
            end
            if (!any_grant && req[cand[ID_W-1:0]]) begin
                grant[cand[ID_W-1:0]] = 1'b1;
                grant_idx             = cand[ID_W-1:0];
                any_grant             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/or_share_arb.sv
// Shares one WIDTH-bit OR datapath among N_REQ requesters with
// round-robin arbitration and a single registered result slot.
// clk : rising-edge clock
// rst : synchronous active-high reset
// bus : or_share_arb_if.slave -- request handshakes/operands in,
//       result handshake/data/id out
module or_share_arb
    import or_share_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input logic          clk,
    input logic          rst,
    or_share_arb_if.slave bus
);

    localparam int unsigned    ID_W = id_width(N_REQ);
    localparam logic [ID_W-1:0] LAST = ID_W'(N_REQ - 1);

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [WIDTH-1:0] res_data_q;
    logic [ID_W-1:0]  res_id_q;

    logic             slot_free;
    logic [N_REQ-1:0] req_qual;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic             any_grant;
    logic [WIDTH-1:0] or_res;

    // Slot may be refilled in the same cycle it drains; reset blocks grants.
    assign slot_free = (state == EMPTY) || bus.res_ready;
    assign req_qual  = bus.req_valid & {N_REQ{slot_free && !rst}};

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req       (req_qual),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // AND-OR select of the granted operand pair, then the shared OR.
    always_comb begin
        or_res = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                or_res = or_res | bus.req_a[i*WIDTH +: WIDTH]
                                | bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            ptr        <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
        end else if (any_grant) begin
            state      <= FULL;
            res_data_q <= or_res;
            res_id_q   <= grant_idx;
            ptr        <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
        end else if (state == FULL && bus.res_ready) begin
            state <= EMPTY;
        end
    end

    assign bus.req_ready = grant;
    assign bus.res_valid = (state == FULL);
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;

endmodule

// File: tb/tb_or_share_arb.sv
// Directed self-checking bench for or_share_arb (N_REQ=4, WIDTH=8).
module tb_or_share_arb;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    or_share_arb_if #(.N_REQ(4), .WIDTH(8)) bus ();

    or_share_arb #(.N_REQ(4), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Operand set where requester i yields a distinct OR result.
    task automatic load_lanes();
        bus.req_a = {8'h08, 8'h04, 8'h02, 8'h01};
        bus.req_b = {8'h10, 8'h20, 8'h40, 8'h80};
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.req_valid = 4'b1111;
        bus.res_ready = 1'b1;
        load_lanes();
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready[%0d]: got %b want 0000", c, bus.req_ready); end
            total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d]: got %b want 0", c, bus.res_valid); end
            total++; if (bus.res_data !== 8'h00) begin bad++; $display("FAIL reset_data[%0d]: got %h want 00", c, bus.res_data); end
            total++; if (bus.res_id !== 2'd0) begin bad++; $display("FAIL reset_id[%0d]: got %0d want 0", c, bus.res_id); end
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bus.req_a     = {8'h11, 8'h0F, 8'h11, 8'h11};
        bus.req_b     = {8'h22, 8'hA0, 8'h22, 8'h22};
        bus.req_valid = 4'b0100;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready[%0d]: got %b want 0100", c, bus.req_ready); end
            tick();
            total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL single_valid[%0d]: got %b want 1", c, bus.res_valid); end
            total++; if (bus.res_data !== 8'hAF) begin bad++; $display("FAIL single_data[%0d]: got %h want af", c, bus.res_data); end
            total++; if (bus.res_id !== 2'd2) begin bad++; $display("FAIL single_id[%0d]: got %0d want 2", c, bus.res_id); end
        end
        // Drain with no new request: valid drops, data/id hold.
        bus.req_valid = 4'b0000;
        tick();
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL drain_valid: got %b want 0", bus.res_valid); end
        total++; if (bus.res_data !== 8'hAF) begin bad++; $display("FAIL drain_data: got %h want af", bus.res_data); end
        total++; if (bus.res_id !== 2'd2) begin bad++; $display("FAIL drain_id: got %0d want 2", bus.res_id); end
    endtask

    task automatic test_fairness();
        logic [7:0] exp_d [4];
        logic [3:0] exp_r;
        exp_d = '{8'h81, 8'h42, 8'h24, 8'h18};
        rst = 1'b1;
        bus.req_valid = 4'b0000;
        tick();
        rst = 1'b0;
        load_lanes();
        bus.req_valid = 4'b1111;
        bus.res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_r = 4'b0001 << (k % 4);
            #1;
            total++; if (bus.req_ready !== exp_r) begin bad++; $display("FAIL fair_ready[%0d]: got %b want %b", k, bus.req_ready, exp_r); end
            tick();
            total++; if (bus.res_id !== 2'(k % 4)) begin bad++; $display("FAIL fair_id[%0d]: got %0d want %0d", k, bus.res_id, k % 4); end
            total++; if (bus.res_data !== exp_d[k % 4]) begin bad++; $display("FAIL fair_data[%0d]: got %h want %h", k, bus.res_data, exp_d[k % 4]); end
        end
    endtask

    task automatic test_backpressure();
        // Slot holds result from requester 3; ptr is back at 0.
        bus.res_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, bus.req_ready); end
            tick();
            total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", c, bus.res_valid); end
            total++; if (bus.res_data !== 8'h18) begin bad++; $display("FAIL bp_data[%0d]: got %h want 18", c, bus.res_data); end
            total++; if (bus.res_id !== 2'd3) begin bad++; $display("FAIL bp_id[%0d]: got %0d want 3", c, bus.res_id); end
        end
        bus.res_ready = 1'b1;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL bp_release_ready: got %b want 0001", bus.req_ready); end
        tick();
        total++; if (bus.res_id !== 2'd0) begin bad++; $display("FAIL bp_release_id: got %0d want 0", bus.res_id); end
        total++; if (bus.res_data !== 8'h81) begin bad++; $display("FAIL bp_release_data: got %h want 81", bus.res_data); end
        bus.req_valid = 4'b0000;
        tick();
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL bp_idle_valid: got %b want 0", bus.res_valid); end
    endtask

    task automatic test_wrap_skip();
        // ptr is 1 here; grant 3 first to reach the wrap point.
        bus.req_valid = 4'b1000;
        tick();
        total++; if (bus.res_id !== 2'd3) begin bad++; $display("FAIL wrap_g3_id: got %0d want 3", bus.res_id); end
        bus.req_valid = 4'b0101;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_ready0: got %b want 0001", bus.req_ready); end
        tick();
        total++; if (bus.res_id !== 2'd0) begin bad++; $display("FAIL wrap_id0: got %0d want 0", bus.res_id); end
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL skip_ready2: got %b want 0100", bus.req_ready); end
        tick();
        total++; if (bus.res_id !== 2'd2) begin bad++; $display("FAIL skip_id2: got %0d want 2", bus.res_id); end
        total++; if (bus.res_data !== 8'h24) begin bad++; $display("FAIL skip_data2: got %h want 24", bus.res_data); end
        bus.req_valid = 4'b0001;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL wrap2_ready0: got %b want 0001", bus.req_ready); end
        tick();
        total++; if (bus.res_id !== 2'd0) begin bad++; $display("FAIL wrap2_id0: got %0d want 0", bus.res_id); end
        bus.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_mid_reset();
        bus.req_valid = 4'b0010;
        bus.res_ready = 1'b1;
        tick();
        total++; if (bus.res_id !== 2'd1) begin bad++; $display("FAIL mr_setup_id: got %0d want 1", bus.res_id); end
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b1001;
        tick();
        total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL mr_held_valid: got %b want 1", bus.res_valid); end
        rst = 1'b1;
        #1;
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL mr_rst_ready: got %b want 0000", bus.req_ready); end
        tick();
        rst = 1'b0;
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL mr_valid: got %b want 0", bus.res_valid); end
        total++; if (bus.res_data !== 8'h00) begin bad++; $display("FAIL mr_data: got %h want 00", bus.res_data); end
        bus.res_ready = 1'b1;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL mr_resume_ready: got %b want 0001", bus.req_ready); end
        tick();
        total++; if (bus.res_id !== 2'd0) begin bad++; $display("FAIL mr_resume_id: got %0d want 0", bus.res_id); end
        total++; if (bus.res_data !== 8'h81) begin bad++; $display("FAIL mr_resume_data: got %h want 81", bus.res_data); end
        bus.req_valid = 4'b0000;
        tick();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_wrap_skip();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
